// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write path: data word, register index
// and a buffered write request.
package rf_write_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef struct packed {
    regbits_t sel;
    word_t    dat;
  } rf_wreq_t;

endpackage

// File: rtl/rf_wreq_fifo.sv
// Small synchronous FIFO of register-file write requests. Pointers carry an
// extra wrap bit so full and empty are told apart without a count register.
module rf_wreq_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     push,
  input  rf_wreq_t push_data,
  input  logic     pop,
  output rf_wreq_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  rf_wreq_t    mem_q [DEPTH];
  rf_wreq_t    mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Sole driver of the register-file write port: pipeline writebacks win, buffered
// long-latency results drain otherwise; also owns the pending-write scoreboard.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        wb_wen,
  input  logic [4:0]  wb_wsel,
  input  logic [31:0] wb_wdat,
  output logic        wb_stall,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_sel,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_sel,
  input  logic [31:0] lu_dat,
  output logic [31:0] busy,
  output logic        err,
  output logic        WEN,
  output logic [4:0]  wsel,
  output logic [31:0] wdat
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  rf_wreq_t    fifo_head;
  rf_wreq_t    fifo_in;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        wb_win;
  logic        clr_hit;
  logic        issue_err;

  logic        wen_q, wen_d;
  logic [4:0]  wsel_q, wsel_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] busy_q, busy_d;
  logic        err_q, err_d;
  logic [SW-1:0] starve_q, starve_d;

  assign fifo_in  = '{sel: lu_sel, dat: lu_dat};
  assign lu_ready = !fifo_full;
  assign wb_stall = (starve_q == STARVE_LIM);
  assign busy     = busy_q;
  assign err      = err_q;
  assign WEN      = wen_q;
  assign wsel     = wsel_q;
  assign wdat     = wdat_q;

  rf_wreq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    wb_win    = wb_wen && (wb_wsel != '0);
    fifo_pop  = !fifo_empty && !wb_win;
    fifo_push = lu_valid && !fifo_full;
    clr_hit   = fifo_pop && (fifo_head.sel != '0);

    wen_d  = 1'b0;
    wsel_d = wsel_q;
    wdat_d = wdat_q;
    if (wb_win) begin
      wen_d  = 1'b1;
      wsel_d = wb_wsel;
      wdat_d = wb_wdat;
    end else if (clr_hit) begin
      wen_d  = 1'b1;
      wsel_d = fifo_head.sel;
      wdat_d = fifo_head.dat;
    end

    // Re-issuing to a register whose result retires this same edge is legal.
    busy_d = busy_q;
    if (clr_hit) begin
      busy_d[fifo_head.sel] = 1'b0;
    end
    if (lu_issue && (lu_issue_sel != '0)) begin
      busy_d[lu_issue_sel] = 1'b1;
    end
    busy_d[0] = 1'b0;

    issue_err = lu_issue && busy_q[lu_issue_sel] &&
                !(clr_hit && (fifo_head.sel == lu_issue_sel));
    err_d = err_q | issue_err | (wb_wen && wb_stall) |
            (lu_valid && !busy_q[lu_sel]);

    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + STARVE_ONE;
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wen_q    <= 1'b0;
      wsel_q   <= '0;
      wdat_q   <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      wen_q    <= wen_d;
      wsel_q   <= wsel_d;
      wdat_q   <= wdat_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomised and directed bench for rf_write_arbiter against a queue-based
// reference model of the write-port arbitration and scoreboard rules.
module tb_rf_write_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        wb_wen;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat;
  logic        wb_stall;
  logic        lu_issue;
  logic [4:0]  lu_issue_sel;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_sel;
  logic [31:0] lu_dat;
  logic [31:0] busy;
  logic        err;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;

  always #5 CLK = ~CLK;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .wb_wen       (wb_wen),
    .wb_wsel      (wb_wsel),
    .wb_wdat      (wb_wdat),
    .wb_stall     (wb_stall),
    .lu_issue     (lu_issue),
    .lu_issue_sel (lu_issue_sel),
    .lu_valid     (lu_valid),
    .lu_ready     (lu_ready),
    .lu_sel       (lu_sel),
    .lu_dat       (lu_dat),
    .busy         (busy),
    .err          (err),
    .WEN          (WEN),
    .wsel         (wsel),
    .wdat         (wdat)
  );

  typedef struct {
    int          sel;
    logic [31:0] dat;
  } ent_t;

  ent_t        mq[$];
  bit          m_busy [32];
  int          m_starve;
  bit          m_err;
  bit          m_wen;
  logic [4:0]  m_wsel;
  logic [31:0] m_wdat;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 1; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_starve = 0;
    m_err    = 1'b0;
    m_wen    = 1'b0;
    m_wsel   = '0;
    m_wdat   = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    wb_wen = 0; wb_wsel = '0; wb_wdat = '0;
    lu_issue = 0; lu_issue_sel = '0; lu_valid = 0; lu_sel = '0; lu_dat = '0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    model_reset();
  endtask

  // One clock: drive inputs, check combinational outputs, advance the model,
  // then check registered outputs after the edge.
  task automatic step(input bit w, input logic [4:0] ws, input logic [31:0] wd,
                      input bit iss, input logic [4:0] isel,
                      input bit lv, input logic [4:0] ls, input logic [31:0] ld);
    bit   win, popped, ready_pre, empty_pre;
    ent_t h;
    @(negedge CLK);
    wb_wen = w; wb_wsel = ws; wb_wdat = wd;
    lu_issue = iss; lu_issue_sel = isel;
    lu_valid = lv; lu_sel = ls; lu_dat = ld;
    #1;
    ready_pre = (mq.size() < DEPTH);
    empty_pre = (mq.size() == 0);
    check_eq("lu_ready", lu_ready, ready_pre);
    check_eq("wb_stall", wb_stall, m_starve == STARVE_MAX);

    win    = w && (ws != 0);
    popped = !empty_pre && !win;
    if (iss && m_busy[isel] && !(popped && mq[0].sel == int'(isel))) m_err = 1'b1;
    if (w && m_starve == STARVE_MAX) m_err = 1'b1;
    if (lv && !m_busy[ls]) m_err = 1'b1;

    m_wen = 1'b0;
    if (win) begin
      m_wen = 1'b1; m_wsel = ws; m_wdat = wd;
    end else if (popped) begin
      h = mq.pop_front();
      if (h.sel != 0) begin
        m_wen = 1'b1; m_wsel = 5'(h.sel); m_wdat = h.dat;
        m_busy[h.sel] = 1'b0;
      end
    end
    if (lv && ready_pre) mq.push_back('{sel: int'(ls), dat: ld});
    if (iss && isel != 0) m_busy[isel] = 1'b1;
    if (empty_pre || popped) m_starve = 0;
    else if (m_starve < STARVE_MAX) m_starve++;

    @(posedge CLK);
    #1;
    check_eq("WEN", WEN, m_wen);
    check_eq("busy", busy, busy_vec());
    check_eq("err", err, m_err);
    if (m_wen) begin
      check_eq("wsel", wsel, m_wsel);
      check_eq("wdat", wdat, m_wdat);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          busy_list[$];
    bit          w, iss, lv;
    logic [4:0]  ws, isel, ls;

    do_reset();
    #1;
    check_eq("rst_WEN", WEN, 0);
    check_eq("rst_wsel", wsel, 0);
    check_eq("rst_wdat", wdat, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_lu_ready", lu_ready, 1);

    step(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    check_eq("pipe_WEN", WEN, 1);
    check_eq("pipe_wsel", wsel, 5);
    check_eq("pipe_wdat", wdat, 32'hDEAD_BEEF);
    step(1, 0, 32'h1111_1111, 0, 0, 0, 0, 0);
    check_eq("pipe_sel0_WEN", WEN, 0);
    check_eq("pipe_sel0_hold", wsel, 5);

    step(0, 0, 0, 1, 9, 0, 0, 0);
    check_eq("issue_busy9", busy[9], 1);
    step(0, 0, 0, 0, 0, 1, 9, 32'h1234);
    idle();
    check_eq("lu_WEN", WEN, 1);
    check_eq("lu_wsel", wsel, 9);
    check_eq("lu_wdat", wdat, 32'h1234);
    check_eq("lu_busy9", busy[9], 0);

    for (int r = 1; r <= 4; r++) step(0, 0, 0, 1, 5'(r), 0, 0, 0);
    for (int r = 1; r <= 4; r++) step(1, 10, 32'h5000 + r, 0, 0, 1, 5'(r), 32'hA0 + r);
    check_eq("fill_lu_ready", lu_ready, 0);
    check_eq("fill_wb_stall", wb_stall, 1);
    for (int r = 1; r <= 4; r++) begin
      idle();
      check_eq("drain_wsel", wsel, r);
      check_eq("drain_wdat", wdat, 32'hA0 + r);
    end
    check_eq("drain_stall", wb_stall, 0);
    check_eq("drain_err", err, 0);

    step(0, 0, 0, 1, 7, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 7, 32'h77);
    step(0, 0, 0, 1, 7, 0, 0, 0);
    check_eq("coll_wsel", wsel, 7);
    check_eq("coll_busy7", busy[7], 1);
    check_eq("coll_err", err, 0);

    do_reset();
    step(0, 0, 0, 1, 3, 0, 0, 0);
    check_eq("err_first_issue", err, 0);
    step(0, 0, 0, 1, 3, 0, 0, 0);
    check_eq("err_double_issue", err, 1);
    repeat (3) idle();
    check_eq("err_sticky", err, 1);
    do_reset();
    #1;
    check_eq("err_cleared", err, 0);

    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        w = ($urandom_range(0, 99) < 55);
        if (m_starve == STARVE_MAX && $urandom_range(0, 9) != 0) w = 0;
        ws = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        iss = ($urandom_range(0, 99) < 20);
        isel = 5'($urandom_range(1, 31));
        for (int t = 0; t < 4 && m_busy[isel] && $urandom_range(0, 9) != 0; t++)
          isel = 5'($urandom_range(1, 31));
        lv = ($urandom_range(0, 99) < 35);
        busy_list.delete();
        for (int i = 1; i < 32; i++) if (m_busy[i]) busy_list.push_back(i);
        if (busy_list.size() > 0 && $urandom_range(0, 9) != 0)
          ls = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
        else
          ls = 5'($urandom_range(0, 31));
        step(w, ws, $urandom, iss, isel, lv, ls, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
